// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the boot loader
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_RUN,
      ST_ERROR
   } loader_state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_CSUM     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ZERO_LEN = 2'b11;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // States in which the inter-byte timeout is armed.
   function automatic logic in_frame(input loader_state_e s);
      return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/boot_timeout_counter.sv
// rtl/boot_timeout_counter.sv - idle-cycle counter with expire pulse
module boot_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q, count_d;

   // Expire is independent of clear so the caller can resolve a same-cycle transfer itself.
   assign expire = enable && (count_q == LAST);

   // Next count: clear has priority, otherwise count up while enabled and saturate at LAST.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream program loader with checksum and CPU reset control
module boot_loader
   import cpu_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter logic [ADDR_WIDTH-1:0] LOAD_BASE = '0,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   input  logic                  cpu_halt,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [7:0]            imem_wdata,
   output logic                  cpu_reset,
   output logic                  load_done,
   output logic                  load_error,
   output logic [1:0]            err_code
);

   loader_state_e         state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [7:0]            sum_q, sum_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;

   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [7:0]            imem_wdata_q, imem_wdata_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  load_done_q, load_done_d;
   logic                  load_error_q, load_error_d;
   logic [1:0]            err_code_q, err_code_d;

   logic                  xfer;
   logic                  expire;
   logic                  go_error;
   logic [1:0]            err_sel;

   // While running, bytes are only taken once the CPU has halted, so a stray sync cannot reload it.
   assign rx_ready = !reset && ((state_q == ST_RUN) ? cpu_halt : 1'b1);
   assign xfer     = rx_valid && rx_ready;

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;
   assign err_code   = err_code_q;

   boot_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (xfer || (state_d != state_q)),
      .enable (in_frame(state_q)),
      .expire (expire)
   );

   // Next-state, checksum/address datapath and registered output values.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sum_d        = sum_q;
      addr_d       = addr_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      cpu_reset_d  = cpu_reset_q;
      load_done_d  = load_done_q;
      load_error_d = load_error_q;
      err_code_d   = err_code_q;
      go_error     = 1'b0;
      err_sel      = ERR_NONE;

      case (state_q)
         ST_IDLE: begin
            if (xfer && (rx_data == SYNC_BYTE)) begin
               state_d = ST_LEN;
            end
         end
         ST_LEN: begin
            if (xfer) begin
               if (rx_data == 8'd0) begin
                  go_error = 1'b1;
                  err_sel  = ERR_ZERO_LEN;
               end else begin
                  cnt_d   = rx_data;
                  sum_d   = rx_data;
                  addr_d  = LOAD_BASE;
                  state_d = ST_DATA;
               end
            end else if (expire) begin
               go_error = 1'b1;
               err_sel  = ERR_TIMEOUT;
            end
         end
         ST_DATA: begin
            if (xfer) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = addr_q;
               imem_wdata_d = rx_data;
               addr_d       = addr_q + 1'b1;
               sum_d        = sum_q + rx_data;
               cnt_d        = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = ST_CSUM;
               end
            end else if (expire) begin
               go_error = 1'b1;
               err_sel  = ERR_TIMEOUT;
            end
         end
         ST_CSUM: begin
            if (xfer) begin
               if (rx_data == sum_q) begin
                  state_d     = ST_RUN;
                  cpu_reset_d = 1'b0;
                  load_done_d = 1'b1;
               end else begin
                  go_error = 1'b1;
                  err_sel  = ERR_CSUM;
               end
            end else if (expire) begin
               go_error = 1'b1;
               err_sel  = ERR_TIMEOUT;
            end
         end
         ST_RUN: begin
            if (xfer && (rx_data == SYNC_BYTE)) begin
               state_d     = ST_LEN;
               cpu_reset_d = 1'b1;
               load_done_d = 1'b0;
            end
         end
         ST_ERROR: begin
            if (xfer && (rx_data == SYNC_BYTE)) begin
               state_d      = ST_LEN;
               load_error_d = 1'b0;
               err_code_d   = ERR_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Every rejection path holds the CPU in reset and reports the cause.
      if (go_error) begin
         state_d      = ST_ERROR;
         load_error_d = 1'b1;
         err_code_d   = err_sel;
         cpu_reset_d  = 1'b1;
         load_done_d  = 1'b0;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'd0;
         sum_q        <= 8'd0;
         addr_q       <= LOAD_BASE;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= LOAD_BASE;
         imem_wdata_q <= 8'd0;
         cpu_reset_q  <= 1'b1;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         err_code_q   <= ERR_NONE;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sum_q        <= sum_d;
         addr_q       <= addr_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_reset_q  <= cpu_reset_d;
         load_done_q  <= load_done_d;
         load_error_q <= load_error_d;
         err_code_q   <= err_code_d;
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader
module tb_boot_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       cpu_halt;

   logic       a_rx_ready, a_we, a_cres, a_done, a_err;
   logic [7:0] a_addr, a_wd;
   logic [1:0] a_code;
   logic       b_rx_ready, b_we, b_cres, b_done, b_err;
   logic [7:0] b_addr, b_wd;
   logic [1:0] b_code;

   int tests = 0;
   int fails = 0;

   logic [7:0] a_log_addr[$];
   logic [7:0] a_log_data[$];
   logic [7:0] b_log_addr[$];
   logic [7:0] b_log_data[$];

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       h;
      logic       rdy;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wd;
      logic       cres;
      logic       done;
      logic       err;
      logic [1:0] code;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   boot_loader dut_a (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (a_rx_ready),
      .cpu_halt   (cpu_halt),
      .imem_we    (a_we),
      .imem_addr  (a_addr),
      .imem_wdata (a_wd),
      .cpu_reset  (a_cres),
      .load_done  (a_done),
      .load_error (a_err),
      .err_code   (a_code)
   );

   boot_loader #(.LOAD_BASE(8'hFE)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (b_rx_ready),
      .cpu_halt   (cpu_halt),
      .imem_we    (b_we),
      .imem_addr  (b_addr),
      .imem_wdata (b_wd),
      .cpu_reset  (b_cres),
      .load_done  (b_done),
      .load_error (b_err),
      .err_code   (b_code)
   );

   // External instruction memory write log for both instances.
   always @(posedge clk) begin
      if (a_we) begin
         a_log_addr.push_back(a_addr);
         a_log_data.push_back(a_wd);
      end
      if (b_we) begin
         b_log_addr.push_back(b_addr);
         b_log_data.push_back(b_wd);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic h, input logic rdy,
                      input logic we, input logic [7:0] addr, input logic [7:0] wd,
                      input logic cres, input logic done, input logic err, input logic [1:0] code);
      vec_t t;
      t.v = v; t.d = d; t.h = h; t.rdy = rdy; t.we = we; t.addr = addr; t.wd = wd;
      t.cres = cres; t.done = done; t.err = err; t.code = code;
      tbl.push_back(t);
   endtask

   // Drive one cycle of input; returns rx_ready as seen before the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic h, output logic rdy);
      rx_valid = v;
      rx_data  = d;
      cpu_halt = h;
      #1;
      rdy = a_rx_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      a_log_addr.delete();
      a_log_data.delete();
      b_log_addr.delete();
      b_log_data.delete();
   endtask

   initial begin
      logic r;

      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      cpu_halt = 1'b0;
      @(posedge clk);
      #1;
      check("reset rx_ready", a_rx_ready, 1'b0);
      @(posedge clk);
      #1;
      check("reset imem_we", a_we, 1'b0);
      check("reset imem_addr", a_addr, 8'h00);
      check("reset imem_addr base FE", b_addr, 8'hFE);
      check("reset imem_wdata", a_wd, 8'h00);
      check("reset cpu_reset", a_cres, 1'b1);
      check("reset load_done", a_done, 1'b0);
      check("reset load_error", a_err, 1'b0);
      check("reset err_code", a_code, 2'b00);
      reset = 1'b0;

      // v   d     h    rdy  we   addr   wd     cres done err  code
      add(1, 8'hA5, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 2'b00);
      add(1, 8'h03, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 2'b00);
      add(1, 8'h10, 0, 1, 1, 8'h00, 8'h10, 1, 0, 0, 2'b00);
      add(1, 8'h20, 0, 1, 1, 8'h01, 8'h20, 1, 0, 0, 2'b00);
      add(1, 8'h30, 0, 1, 1, 8'h02, 8'h30, 1, 0, 0, 2'b00);
      add(1, 8'h63, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 2'b00);
      add(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 2'b00);
      add(1, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 2'b00);
      add(1, 8'h01, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 2'b00);
      add(1, 8'hA5, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0, 2'b00);
      add(1, 8'h03, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0, 2'b00);
      add(1, 8'h10, 1, 1, 1, 8'h00, 8'h10, 1, 0, 0, 2'b00);
      add(1, 8'h20, 1, 1, 1, 8'h01, 8'h20, 1, 0, 0, 2'b00);
      add(1, 8'h30, 1, 1, 1, 8'h02, 8'h30, 1, 0, 0, 2'b00);
      add(1, 8'h64, 1, 1, 0, 8'h00, 8'h00, 1, 0, 1, 2'b01);
      add(0, 8'h00, 1, 1, 0, 8'h00, 8'h00, 1, 0, 1, 2'b01);
      add(1, 8'h00, 0, 1, 0, 8'h00, 8'h00, 1, 0, 1, 2'b01);
      add(1, 8'hA5, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 2'b00);
      add(1, 8'h03, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 2'b00);
      add(1, 8'h10, 0, 1, 1, 8'h00, 8'h10, 1, 0, 0, 2'b00);
      add(0, 8'h00, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 2'b00);
      add(1, 8'h20, 0, 1, 1, 8'h01, 8'h20, 1, 0, 0, 2'b00);
      add(1, 8'h30, 0, 1, 1, 8'h02, 8'h30, 1, 0, 0, 2'b00);
      add(1, 8'h63, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 2'b00);
      add(1, 8'hA5, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0, 2'b00);
      add(1, 8'h01, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0, 2'b00);
      add(1, 8'h55, 1, 1, 1, 8'h00, 8'h55, 1, 0, 0, 2'b00);
      add(1, 8'h56, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0, 2'b00);
      add(1, 8'hA5, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0, 2'b00);
      add(1, 8'h00, 1, 1, 0, 8'h00, 8'h00, 1, 0, 1, 2'b11);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].h, r);
         check($sformatf("vec%0d rx_ready", i), r, tbl[i].rdy);
         check($sformatf("vec%0d imem_we", i), a_we, tbl[i].we);
         if (tbl[i].we) begin
            check($sformatf("vec%0d imem_addr", i), a_addr, tbl[i].addr);
            check($sformatf("vec%0d imem_wdata", i), a_wd, tbl[i].wd);
         end
         check($sformatf("vec%0d cpu_reset", i), a_cres, tbl[i].cres);
         check($sformatf("vec%0d load_done", i), a_done, tbl[i].done);
         check($sformatf("vec%0d load_error", i), a_err, tbl[i].err);
         check($sformatf("vec%0d err_code", i), a_code, tbl[i].code);
      end

      // Timeout: one data byte then silence for exactly TIMEOUT_CYCLES cycles.
      clear_logs();
      step(1, 8'hA5, 0, r);
      step(1, 8'h02, 0, r);
      step(1, 8'h11, 0, r);
      for (int i = 0; i < 1023; i++) step(0, 8'h00, 0, r);
      check("timeout not yet err_code", a_code, 2'b00);
      check("timeout not yet load_error", a_err, 1'b0);
      step(0, 8'h00, 0, r);
      check("timeout err_code", a_code, 2'b10);
      check("timeout load_error", a_err, 1'b1);
      check("timeout cpu_reset", a_cres, 1'b1);
      check("timeout write count", a_log_addr.size(), 1);

      // A transfer in the expiring cycle beats the timeout.
      clear_logs();
      step(1, 8'hA5, 0, r);
      step(1, 8'h02, 0, r);
      step(1, 8'h11, 0, r);
      for (int i = 0; i < 1023; i++) step(0, 8'h00, 0, r);
      step(1, 8'h22, 0, r);
      check("late byte load_error", a_err, 1'b0);
      check("late byte imem_we", a_we, 1'b1);
      check("late byte imem_addr", a_addr, 8'h01);
      check("late byte imem_wdata", a_wd, 8'h22);
      step(1, 8'h35, 0, r);
      check("late frame load_done", a_done, 1'b1);
      check("late frame cpu_reset", a_cres, 1'b0);
      check("late frame err_code", a_code, 2'b00);

      // Address wrap on the FE-based instance.
      step(1, 8'hA5, 1, r);
      clear_logs();
      step(1, 8'h03, 1, r);
      step(1, 8'h01, 1, r);
      step(1, 8'h02, 1, r);
      step(1, 8'h03, 1, r);
      step(1, 8'h09, 1, r);
      check("wrap write count", b_log_addr.size(), 3);
      if (b_log_addr.size() == 3) begin
         check("wrap addr0", b_log_addr[0], 8'hFE);
         check("wrap addr1", b_log_addr[1], 8'hFF);
         check("wrap addr2", b_log_addr[2], 8'h00);
         check("wrap data0", b_log_data[0], 8'h01);
         check("wrap data2", b_log_data[2], 8'h03);
      end
      check("wrap load_done", b_done, 1'b1);
      check("wrap base0 load_done", a_done, 1'b1);
      if (a_log_addr.size() == 3) check("base0 addr2", a_log_addr[2], 8'h02);
      else check("base0 write count", a_log_addr.size(), 3);

      // Reset in DATA after the first of three bytes, then garbage before a good frame.
      step(1, 8'hA5, 1, r);
      step(1, 8'h03, 1, r);
      step(1, 8'h41, 1, r);
      check("midframe imem_we", a_we, 1'b1);
      check("midframe imem_wdata", a_wd, 8'h41);
      reset    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h42;
      #1;
      check("midframe rx_ready in reset", a_rx_ready, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("midframe rst imem_we", a_we, 1'b0);
      check("midframe rst imem_addr", a_addr, 8'h00);
      check("midframe rst imem_addr FE", b_addr, 8'hFE);
      check("midframe rst imem_wdata", a_wd, 8'h00);
      check("midframe rst cpu_reset", a_cres, 1'b1);
      check("midframe rst load_done", a_done, 1'b0);
      check("midframe rst load_error", a_err, 1'b0);
      check("midframe rst err_code", a_code, 2'b00);
      clear_logs();
      step(1, 8'h00, 0, r);
      step(1, 8'hFF, 0, r);
      step(1, 8'hA5, 0, r);
      step(1, 8'h01, 0, r);
      step(1, 8'h77, 0, r);
      step(1, 8'h78, 0, r);
      check("post reset load_done", a_done, 1'b1);
      check("post reset cpu_reset", a_cres, 1'b0);
      check("post reset write count", a_log_addr.size(), 1);
      if (a_log_addr.size() == 1) begin
         check("post reset addr", a_log_addr[0], 8'h00);
         check("post reset data", a_log_data[0], 8'h77);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
